// File: rtl/minisrc_ctrl_pkg.sv
// Shared encodings for the MiniSRC control unit: opcodes, states, control-bit
// positions and per-opcode sequence length.
package minisrc_ctrl_pkg;

  localparam int OP_W   = 5;
  localparam int BUS_W  = 8;
  localparam int LD_W   = 10;
  localparam int REG_W  = 6;
  localparam int ALU_W  = 13;

  localparam logic [OP_W-1:0] OP_LD   = 5'd0;
  localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OP_ST   = 5'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OP_SHR  = 5'd5;
  localparam logic [OP_W-1:0] OP_SHRA = 5'd6;
  localparam logic [OP_W-1:0] OP_SHL  = 5'd7;
  localparam logic [OP_W-1:0] OP_ROR  = 5'd8;
  localparam logic [OP_W-1:0] OP_ROL  = 5'd9;
  localparam logic [OP_W-1:0] OP_AND  = 5'd10;
  localparam logic [OP_W-1:0] OP_OR   = 5'd11;
  localparam logic [OP_W-1:0] OP_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OP_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd15;
  localparam logic [OP_W-1:0] OP_DIV  = 5'd16;
  localparam logic [OP_W-1:0] OP_NEG  = 5'd17;
  localparam logic [OP_W-1:0] OP_NOT  = 5'd18;
  localparam logic [OP_W-1:0] OP_BR   = 5'd19;
  localparam logic [OP_W-1:0] OP_JR   = 5'd20;
  localparam logic [OP_W-1:0] OP_JAL  = 5'd21;
  localparam logic [OP_W-1:0] OP_IN   = 5'd22;
  localparam logic [OP_W-1:0] OP_OUT  = 5'd23;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd24;
  localparam logic [OP_W-1:0] OP_MFLO = 5'd25;
  localparam logic [OP_W-1:0] OP_NOP  = 5'd26;
  localparam logic [OP_W-1:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3,
    ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7,
    ST_IDLE = 4'd8, ST_HALT = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    CL_RTYPE, CL_IMM, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY, CL_BR,
    CL_JR, CL_JAL, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_NOP, CL_HALT
  } op_class_t;

  localparam int B_PC = 7, B_ZLO = 6, B_ZHI = 5, B_MDR = 4;
  localparam int B_HI = 3, B_LO = 2, B_INP = 1, B_C = 0;

  localparam int L_PC = 9, L_IR = 8, L_MAR = 7, L_MDR = 6, L_Y = 5;
  localparam int L_Z = 4, L_HI = 3, L_LO = 2, L_CON = 1, L_OUTP = 0;

  localparam int R_GRA = 5, R_GRB = 4, R_GRC = 3, R_RIN = 2, R_ROUT = 1, R_BA = 0;

  localparam int M_READ = 1, M_WRITE = 0;

  localparam int A_AND = 12, A_OR = 11, A_ADD = 10, A_SUB = 9, A_MUL = 8;
  localparam int A_DIV = 7, A_SHR = 6, A_SHRA = 5, A_SHL = 4, A_ROR = 3;
  localparam int A_ROL = 2, A_NEG = 1, A_NOT = 0;

  // Final T-step of each instruction; unlisted opcodes finish at T3.
  function automatic state_t last_step(input logic [OP_W-1:0] op);
    state_t s;
    case (op)
      OP_LD, OP_ST:                          s = ST_T7;
      OP_MUL, OP_DIV, OP_BR:                 s = ST_T6;
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:      s = ST_T5;
      OP_JAL, OP_NEG, OP_NOT:                s = ST_T4;
      default:                               s = ST_T3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/minisrc_op_decode.sv
// Combinational opcode decode: instruction class and the ALU one-hot used in
// that class's ALU step.
module minisrc_op_decode
  import minisrc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  output op_class_t        op_class,
  output logic [ALU_W-1:0] alu
);

  always_comb begin
    op_class = CL_NOP;
    alu      = '0;
    case (opcode)
      OP_ADD:  begin op_class = CL_RTYPE;  alu[A_ADD]  = 1'b1; end
      OP_SUB:  begin op_class = CL_RTYPE;  alu[A_SUB]  = 1'b1; end
      OP_SHR:  begin op_class = CL_RTYPE;  alu[A_SHR]  = 1'b1; end
      OP_SHRA: begin op_class = CL_RTYPE;  alu[A_SHRA] = 1'b1; end
      OP_SHL:  begin op_class = CL_RTYPE;  alu[A_SHL]  = 1'b1; end
      OP_ROR:  begin op_class = CL_RTYPE;  alu[A_ROR]  = 1'b1; end
      OP_ROL:  begin op_class = CL_RTYPE;  alu[A_ROL]  = 1'b1; end
      OP_AND:  begin op_class = CL_RTYPE;  alu[A_AND]  = 1'b1; end
      OP_OR:   begin op_class = CL_RTYPE;  alu[A_OR]   = 1'b1; end
      OP_ADDI: begin op_class = CL_IMM;    alu[A_ADD]  = 1'b1; end
      OP_ANDI: begin op_class = CL_IMM;    alu[A_AND]  = 1'b1; end
      OP_ORI:  begin op_class = CL_IMM;    alu[A_OR]   = 1'b1; end
      OP_LD:   begin op_class = CL_LD;     alu[A_ADD]  = 1'b1; end
      OP_LDI:  begin op_class = CL_LDI;    alu[A_ADD]  = 1'b1; end
      OP_ST:   begin op_class = CL_ST;     alu[A_ADD]  = 1'b1; end
      OP_MUL:  begin op_class = CL_MULDIV; alu[A_MUL]  = 1'b1; end
      OP_DIV:  begin op_class = CL_MULDIV; alu[A_DIV]  = 1'b1; end
      OP_NEG:  begin op_class = CL_UNARY;  alu[A_NEG]  = 1'b1; end
      OP_NOT:  begin op_class = CL_UNARY;  alu[A_NOT]  = 1'b1; end
      OP_BR:   begin op_class = CL_BR;     alu[A_ADD]  = 1'b1; end
      OP_JR:   op_class = CL_JR;
      OP_JAL:  op_class = CL_JAL;
      OP_MFHI: op_class = CL_MFHI;
      OP_MFLO: op_class = CL_MFLO;
      OP_IN:   op_class = CL_IN;
      OP_OUT:  op_class = CL_OUT;
      OP_HALT: op_class = CL_HALT;
      default: op_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/minisrc_control_unit.sv
// MiniSRC microsequencer: fetch/decode/execute stepping with halt/run control.
// Optional memory-wait handshake on Mem_Ready when CU_MEMWAIT_EN is defined.
//
//   state | meaning
//   IDLE  | after reset, waiting for AUTO_RUN or Run
//   T0-T2 | instruction fetch
//   T3-T7 | execute, length set by opcode
//   HALT  | halt executed, waiting for Run
module minisrc_control_unit
  import minisrc_ctrl_pkg::*;
#(
  parameter int   WORD_W   = 32,
  parameter int   OPCODE_W = 5,
  parameter logic AUTO_RUN = 1'b1
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [WORD_W-1:0] IR,
  input  logic              Con_FF,
  input  logic              Mem_Ready,
  input  logic              Run,
  output logic [BUS_W-1:0]  Bus_Sel,
  output logic [LD_W-1:0]   Ld_Sel,
  output logic [REG_W-1:0]  Reg_Ctl,
  output logic [1:0]        Mem_Ctl,
  output logic              IncPC,
  output logic [ALU_W-1:0]  Alu_Sel,
  output logic [3:0]        Step,
  output logic              Halted
);

  state_t           state, state_nx;
  op_class_t        op_class;
  logic [ALU_W-1:0] alu_dec;
  logic [OPCODE_W-1:0] opcode;
  logic             mem_hold;

  assign opcode = IR[WORD_W-1 -: OPCODE_W];

  logic unused_ir;
  assign unused_ir = ^IR[WORD_W-OPCODE_W-1:0];

  minisrc_op_decode u_op_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .alu      (alu_dec)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state <= ST_IDLE;
    else        state <= state_nx;
  end

`ifdef CU_MEMWAIT_EN
  assign mem_hold = !Mem_Ready &&
                    ((state == ST_T1) ||
                     (state == ST_T6 && op_class == CL_LD) ||
                     (state == ST_T7 && op_class == CL_ST));
`else
  assign mem_hold = 1'b0;
  logic unused_mem_ready;
  assign unused_mem_ready = Mem_Ready;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (AUTO_RUN || Run) state_nx = ST_T0;
      ST_HALT: if (Run) state_nx = ST_T0;
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        if (mem_hold)
          state_nx = state;
        else if (state == last_step(opcode))
          state_nx = (op_class == CL_HALT) ? ST_HALT : ST_T0;
        else
          state_nx = state_t'(state + 4'd1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign Step   = state;
  assign Halted = (state == ST_HALT);

  // Control outputs: pure decode of the registered state and IR.
  always_comb begin
    Bus_Sel = '0;
    Ld_Sel  = '0;
    Reg_Ctl = '0;
    Mem_Ctl = '0;
    IncPC   = 1'b0;
    Alu_Sel = '0;
    case (state)
      ST_T0: begin
        Bus_Sel[B_PC] = 1'b1; Ld_Sel[L_MAR] = 1'b1; IncPC = 1'b1; Ld_Sel[L_Z] = 1'b1;
      end
      ST_T1: begin
        Bus_Sel[B_ZLO] = 1'b1; Ld_Sel[L_PC] = 1'b1; Mem_Ctl[M_READ] = 1'b1; Ld_Sel[L_MDR] = 1'b1;
      end
      ST_T2: begin
        Bus_Sel[B_MDR] = 1'b1; Ld_Sel[L_IR] = 1'b1;
      end
      ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
        case (op_class)
          CL_RTYPE, CL_IMM: begin
            if (state == ST_T3) begin
              Reg_Ctl[R_GRB] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Ld_Sel[L_Y] = 1'b1;
            end else if (state == ST_T4) begin
              if (op_class == CL_RTYPE) begin
                Reg_Ctl[R_GRC] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1;
              end else begin
                Bus_Sel[B_C] = 1'b1;
              end
              Alu_Sel = alu_dec; Ld_Sel[L_Z] = 1'b1;
            end else if (state == ST_T5) begin
              Bus_Sel[B_ZLO] = 1'b1; Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_RIN] = 1'b1;
            end
          end
          CL_LD, CL_LDI, CL_ST: begin
            case (state)
              ST_T3: begin
                Reg_Ctl[R_GRB] = 1'b1; Reg_Ctl[R_BA] = 1'b1; Ld_Sel[L_Y] = 1'b1;
              end
              ST_T4: begin
                Bus_Sel[B_C] = 1'b1; Alu_Sel = alu_dec; Ld_Sel[L_Z] = 1'b1;
              end
              ST_T5: begin
                Bus_Sel[B_ZLO] = 1'b1;
                if (op_class == CL_LDI) begin
                  Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_RIN] = 1'b1;
                end else begin
                  Ld_Sel[L_MAR] = 1'b1;
                end
              end
              ST_T6: begin
                Ld_Sel[L_MDR] = 1'b1;
                if (op_class == CL_ST) begin
                  Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1;
                end else begin
                  Mem_Ctl[M_READ] = 1'b1;
                end
              end
              default: begin
                if (op_class == CL_ST) begin
                  Mem_Ctl[M_WRITE] = 1'b1;
                end else begin
                  Bus_Sel[B_MDR] = 1'b1; Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_RIN] = 1'b1;
                end
              end
            endcase
          end
          CL_MULDIV: begin
            case (state)
              ST_T3: begin
                Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Ld_Sel[L_Y] = 1'b1;
              end
              ST_T4: begin
                Reg_Ctl[R_GRB] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Alu_Sel = alu_dec; Ld_Sel[L_Z] = 1'b1;
              end
              ST_T5: begin
                Bus_Sel[B_ZLO] = 1'b1; Ld_Sel[L_LO] = 1'b1;
              end
              default: begin
                Bus_Sel[B_ZHI] = 1'b1; Ld_Sel[L_HI] = 1'b1;
              end
            endcase
          end
          CL_UNARY: begin
            if (state == ST_T3) begin
              Reg_Ctl[R_GRB] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Alu_Sel = alu_dec; Ld_Sel[L_Z] = 1'b1;
            end else begin
              Bus_Sel[B_ZLO] = 1'b1; Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_RIN] = 1'b1;
            end
          end
          CL_BR: begin
            case (state)
              ST_T3: begin
                Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Ld_Sel[L_CON] = 1'b1;
              end
              ST_T4: begin
                Bus_Sel[B_PC] = 1'b1; Ld_Sel[L_Y] = 1'b1;
              end
              ST_T5: begin
                Bus_Sel[B_C] = 1'b1; Alu_Sel = alu_dec; Ld_Sel[L_Z] = 1'b1;
              end
              default: begin
                Bus_Sel[B_ZLO] = Con_FF; Ld_Sel[L_PC] = Con_FF;
              end
            endcase
          end
          CL_JR: begin
            Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Ld_Sel[L_PC] = 1'b1;
          end
          CL_JAL: begin
            if (state == ST_T3) begin
              Bus_Sel[B_PC] = 1'b1; Reg_Ctl[R_GRB] = 1'b1; Reg_Ctl[R_RIN] = 1'b1;
            end else begin
              Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Ld_Sel[L_PC] = 1'b1;
            end
          end
          CL_MFHI, CL_MFLO, CL_IN: begin
            Bus_Sel[B_HI]  = (op_class == CL_MFHI);
            Bus_Sel[B_LO]  = (op_class == CL_MFLO);
            Bus_Sel[B_INP] = (op_class == CL_IN);
            Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_RIN] = 1'b1;
          end
          CL_OUT: begin
            Reg_Ctl[R_GRA] = 1'b1; Reg_Ctl[R_ROUT] = 1'b1; Ld_Sel[L_OUTP] = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
